// File: rtl/hs_arb_pkg.sv
// Shared types and constants for the hiscore RAM arbiter.
package hs_arb_pkg;

    localparam int HS_SETTLE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_SETTLE,
        ST_GRANT,
        ST_DRAIN
    } hs_arb_state_t;

endpackage

// File: rtl/hs_rd_pipe.sv
// RD_LAT-deep shift register of honoured strobes; drives hs_valid and the
// "pipeline empty" condition used to leave DRAIN.
module hs_rd_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strobe_i,
    output logic valid_o,
    output logic empty_o
);

    logic [RD_LAT:1] vld_pipe_q;
    logic [RD_LAT:1] vld_pipe_d;

    generate
        if (RD_LAT > 1) begin : g_deep
            assign vld_pipe_d = {vld_pipe_q[RD_LAT-1:1], strobe_i};
        end else begin : g_single
            assign vld_pipe_d = strobe_i;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) vld_pipe_q <= '0;
        else         vld_pipe_q <= vld_pipe_d;
    end

    assign valid_o = vld_pipe_q[RD_LAT];
    assign empty_o = ~|vld_pipe_q;

endmodule

// File: rtl/hs_ram_arbiter.sv
// Hands the work-RAM port from the CPU to the hiscore engine: pause the CPU,
// wait for halt + settle, grant, then drain outstanding reads before returning.
module hs_ram_arbiter
    import hs_arb_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int SETTLE = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          hs_req,
    input  logic          hs_strobe,
    input  logic          hs_write,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_valid,
    output logic          hs_grant,
    output logic          hs_abort,
    output logic          pause_req,
    input  logic          cpu_paused,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [HS_SETTLE_W-1:0] SETTLE_INIT = HS_SETTLE_W'(SETTLE - 1);

    hs_arb_state_t          state_q, state_d;
    logic [HS_SETTLE_W-1:0] cnt_q, cnt_d;
    logic                   pause_req_q, hs_grant_q, hs_abort_q;
    logic                   strobe_ok;
    logic                   pipe_empty;

    assign strobe_ok = (state_q == ST_GRANT) && hs_strobe;

    hs_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk_i    (clk_sys),
        .rst_ni   (reset_n),
        .strobe_i (strobe_ok),
        .valid_o  (hs_valid),
        .empty_o  (pipe_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hs_req) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (!hs_req) begin
                    state_d = ST_IDLE;
                end else if (cpu_paused) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_INIT;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 1'b1;
                if (!hs_req)          state_d = ST_IDLE;
                else if (!cpu_paused) state_d = ST_PAUSE;
                else if (cnt_q == '0) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                // Losing the halt and withdrawing the request both drain; only
                // the former is flagged as an abort.
                if (!cpu_paused || !hs_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pipe_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pause_req_q <= 1'b0;
            hs_grant_q  <= 1'b0;
            hs_abort_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pause_req_q <= (state_d != ST_IDLE);
            hs_grant_q  <= (state_d == ST_GRANT);
            hs_abort_q  <= (state_q == ST_GRANT) && !cpu_paused;
        end
    end

    // Port mux follows state directly so reset returns the port to the CPU
    // without waiting for a clock.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we;
        if (state_q == ST_GRANT) begin
            ram_addr  = hs_addr;
            ram_wdata = hs_wdata;
            ram_we    = hs_strobe && hs_write;
        end else if (state_q == ST_DRAIN) begin
            ram_we    = 1'b0;
        end
    end

    assign pause_req = pause_req_q;
    assign hs_grant  = hs_grant_q;
    assign hs_abort  = hs_abort_q;
    assign hs_rdata  = ram_rdata;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter (SETTLE=4, RD_LAT=1) with a registered RAM model.
module tb_hs_ram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        hs_req, hs_strobe, hs_write, cpu_paused, cpu_we;
    logic [15:0] hs_addr, cpu_addr, ram_addr;
    logic [7:0]  hs_wdata, cpu_wdata, ram_wdata, ram_rdata, hs_rdata;
    logic        hs_valid, hs_grant, hs_abort, pause_req, ram_we;

    logic [7:0]  mem [0:65535];

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [7:0] HS_WD  = 8'hA5;
    localparam logic [7:0] CPU_WD = 8'h3C;

    always #5 clk_sys = ~clk_sys;

    hs_ram_arbiter #(.AW(16), .DW(8), .SETTLE(4), .RD_LAT(1)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .hs_req     (hs_req),
        .hs_strobe  (hs_strobe),
        .hs_write   (hs_write),
        .hs_addr    (hs_addr),
        .hs_wdata   (hs_wdata),
        .hs_rdata   (hs_rdata),
        .hs_valid   (hs_valid),
        .hs_grant   (hs_grant),
        .hs_abort   (hs_abort),
        .pause_req  (pause_req),
        .cpu_paused (cpu_paused),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    // One-cycle-latency synchronous RAM
    always @(posedge clk_sys) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    typedef struct {
        logic        req, paused, stb, wr, cwe;
        logic [15:0] haddr, caddr;
        logic        e_hs, e_we;
        logic        e_preq, e_grant, e_valid, e_abort;
        logic        chk_rd;
        logic [7:0]  e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic req, paused, stb, wr, cwe,
                                input logic [15:0] haddr, caddr,
                                input logic e_hs, e_we, e_preq, e_grant, e_valid, e_abort,
                                input logic chk_rd, input logic [7:0] e_rd);
        vec_t v;
        v.req = req; v.paused = paused; v.stb = stb; v.wr = wr; v.cwe = cwe;
        v.haddr = haddr; v.caddr = caddr;
        v.e_hs = e_hs; v.e_we = e_we;
        v.e_preq = e_preq; v.e_grant = e_grant; v.e_valid = e_valid; v.e_abort = e_abort;
        v.chk_rd = chk_rd; v.e_rd = e_rd;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    // Drive a row, check the combinational port mux before the edge and the
    // registered outputs after it.
    task automatic apply(input int idx, input vec_t v);
        hs_req     = v.req;
        cpu_paused = v.paused;
        hs_strobe  = v.stb;
        hs_write   = v.wr;
        cpu_we     = v.cwe;
        hs_addr    = v.haddr;
        cpu_addr   = v.caddr;
        #1;
        chk($sformatf("r%0d_ram_addr", idx), ram_addr, v.e_hs ? v.haddr : v.caddr);
        chk($sformatf("r%0d_ram_wdata", idx), ram_wdata, v.e_hs ? HS_WD : CPU_WD);
        chk($sformatf("r%0d_ram_we", idx), ram_we, v.e_we);
        @(posedge clk_sys);
        #1;
        chk($sformatf("r%0d_pause_req", idx), pause_req, v.e_preq);
        chk($sformatf("r%0d_hs_grant", idx), hs_grant, v.e_grant);
        chk($sformatf("r%0d_hs_valid", idx), hs_valid, v.e_valid);
        chk($sformatf("r%0d_hs_abort", idx), hs_abort, v.e_abort);
        if (v.chk_rd) chk($sformatf("r%0d_hs_rdata", idx), hs_rdata, v.e_rd);
    endtask

    initial begin
        reset_n = 1'b0; hs_req = 0; hs_strobe = 0; hs_write = 0; cpu_paused = 0; cpu_we = 0;
        hs_addr = 16'h0; cpu_addr = 16'h0100; hs_wdata = HS_WD; cpu_wdata = CPU_WD;

        //  req pau stb wr cwe haddr     caddr      hs we  preq gnt vld abt chk rd
        // Basic session: paused 3 cycles after req, grant 4 edges later
        add(1, 0, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 1, 0, 0, 0, 8'h00);
        // Write A5 then read back, CPU writing 0x6000 the whole time
        add(1, 1, 1, 1, 1, 16'h6010, 16'h6000, 1, 1, 1, 1, 1, 0, 0, 8'h00);
        add(1, 1, 1, 0, 1, 16'h6010, 16'h6000, 1, 0, 1, 1, 1, 0, 1, 8'hA5);
        add(1, 1, 0, 0, 1, 16'h1234, 16'h6000, 1, 0, 1, 1, 0, 0, 0, 8'h00);
        // Release: DRAIN blocks cpu_we and ignores strobes, then IDLE passthrough
        add(0, 1, 0, 0, 1, 16'h1234, 16'h6000, 1, 0, 1, 0, 0, 0, 0, 8'h00);
        add(0, 1, 1, 1, 1, 16'h1234, 16'h6000, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 0, 0, 0, 1, 16'h1234, 16'h6001, 0, 1, 0, 0, 0, 0, 0, 8'h00);
        // Request withdrawn in SETTLE
        add(1, 0, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(0, 1, 1, 1, 0, 16'h6010, 16'h6000, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 0, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // cpu_paused drops in SETTLE -> back to PAUSE, full settle restarts
        add(1, 0, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 0, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 1, 0, 0, 0, 8'h00);
        // Abort with a read in flight (req drops too: abort must still win)
        add(0, 0, 1, 0, 0, 16'h6010, 16'h6000, 1, 0, 1, 0, 1, 1, 1, 8'hA5);
        add(0, 0, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(0, 0, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        // Back-to-back session up to GRANT for the reset test
        add(1, 0, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 0, 0, 16'h6010, 16'h6000, 0, 0, 1, 1, 0, 0, 0, 8'h00);

        // Reset state
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_pause_req", pause_req, 1'b0);
        chk("rst_hs_grant", hs_grant, 1'b0);
        chk("rst_hs_valid", hs_valid, 1'b0);
        chk("rst_hs_abort", hs_abort, 1'b0);
        chk("rst_ram_addr", ram_addr, 16'h0100);
        reset_n = 1'b1;

        foreach (vecs[i]) apply(i, vecs[i]);

        // Asynchronous reset while granted with a write strobe pending
        hs_strobe = 1; hs_write = 1; hs_addr = 16'h6020; cpu_we = 0; cpu_addr = 16'h0042;
        #1;
        chk("pre_rst_ram_addr", ram_addr, 16'h6020);
        chk("pre_rst_ram_we", ram_we, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_pause_req", pause_req, 1'b0);
        chk("arst_hs_grant", hs_grant, 1'b0);
        chk("arst_hs_abort", hs_abort, 1'b0);
        chk("arst_hs_valid", hs_valid, 1'b0);
        chk("arst_ram_addr", ram_addr, 16'h0042);
        chk("arst_ram_wdata", ram_wdata, CPU_WD);
        chk("arst_ram_we", ram_we, 1'b0);
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1; hs_req = 0; hs_strobe = 0; hs_write = 0;
        @(posedge clk_sys);
        #1;
        chk("post_rst_pause_req", pause_req, 1'b0);
        chk("post_rst_hs_valid", hs_valid, 1'b0);
        hs_req = 1;
        @(posedge clk_sys);
        #1;
        chk("post_rst_idle_to_pause", pause_req, 1'b1);
        chk("post_rst_grant", hs_grant, 1'b0);
        hs_req = 0;
        @(posedge clk_sys);
        #1;
        chk("post_rst_withdraw", pause_req, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
